// File: rtl/patchify_scheduler.sv
// patchify_scheduler: round-robin owner of the shared image patchifier.
// Grants one requester, pulses pf_en, waits for the patchifier DONE state
// (with timeout), streams patch indices downstream, then releases the
// patchifier and pulses done[] to the owner. All outputs are decoded from
// registered state.
module patchify_scheduler #(
    parameter int unsigned NUM_REQ           = 2,
    parameter int unsigned REQ_ID_W          = 1,
    parameter int unsigned TOTAL_NUM_PATCHES = 4,
    parameter int unsigned PATCH_IDX_W       = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 1024,
    parameter int unsigned TO_W              = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     grant,
    output logic [REQ_ID_W-1:0]    img_sel,
    output logic                   pf_en,
    input  logic [2:0]             pf_state,
    output logic                   pf_output_taken,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PATCH_IDX_W-1:0] out_patch_idx,
    output logic                   out_last,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_STREAM  = 3'd3,
        S_RELEASE = 3'd4,
        S_DRAIN   = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam logic [2:0]             PF_IDLE  = 3'b000;
    localparam logic [2:0]             PF_DONE  = 3'b100;
    localparam logic [PATCH_IDX_W-1:0] LAST_IDX = PATCH_IDX_W'(TOTAL_NUM_PATCHES - 1);
    localparam logic [TO_W-1:0]        TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q,   state_d;
    logic [NUM_REQ-1:0]     grant_q,   grant_d;
    logic [REQ_ID_W-1:0]    img_sel_q, img_sel_d;
    logic [REQ_ID_W-1:0]    ptr_q,     ptr_d;
    logic [PATCH_IDX_W-1:0] idx_q,     idx_d;
    logic [TO_W-1:0]        cnt_q,     cnt_d;
    logic                   err_q,     err_d;

    logic                   arb_found;
    logic [REQ_ID_W-1:0]    arb_win;
    int unsigned            arb_cand;

    // Round-robin search: first set req bit at or above ptr_q, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            arb_cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!arb_found && req[REQ_ID_W'(arb_cand)]) begin
                arb_found = 1'b1;
                arb_win   = REQ_ID_W'(arb_cand);
            end
        end
    end

    // Next-state logic for the job sequencer and its datapath registers.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        img_sel_d = img_sel_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d   = NUM_REQ'(1) << arb_win;
                    img_sel_d = arb_win;
                    ptr_d     = REQ_ID_W'((32'(arb_win) + 1) % NUM_REQ);
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // DONE wins over a timeout landing on the same cycle.
                if (pf_state == PF_DONE) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end else if (cnt_q == TO_LAST) begin
                    grant_d = '0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d = idx_q + PATCH_IDX_W'(1);
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pf_state == PF_IDLE) begin
                    grant_d = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                grant_d = '0;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            img_sel_q <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            img_sel_q <= img_sel_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign grant           = grant_q;
    assign img_sel         = img_sel_q;
    assign pf_en           = (state_q == S_START);
    assign pf_output_taken = (state_q == S_RELEASE);
    assign out_valid       = (state_q == S_STREAM);
    assign out_patch_idx   = idx_q;
    assign out_last        = (idx_q == LAST_IDX);
    assign done            = (state_q == S_RELEASE) ? grant_q : '0;
    assign busy            = (state_q != S_IDLE);
    assign err             = err_q;

endmodule
